// File: rtl/global_params.sv
// Global NoC parameters and the output-port direction encoding shared by
// the routing blocks. Bit order of the one-hot route vector follows dir_e:
// {local, west, south, east, north}.
package global_params;

    localparam int MESH_SIDE = 3;

    typedef enum logic [2:0] {
        NORTH = 3'd0,
        EAST  = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        LOCAL = 3'd4
    } dir_e;

    localparam int DIR_N = 5;

    // One-hot encoding of a direction, bit index equal to the enum value
    function automatic logic [DIR_N-1:0] dir_onehot(input dir_e dir);
        logic [DIR_N-1:0] oh;
        oh = {DIR_N{1'b0}};
        case (dir)
            NORTH:   oh = 5'b00001;
            EAST:    oh = 5'b00010;
            SOUTH:   oh = 5'b00100;
            WEST:    oh = 5'b01000;
            LOCAL:   oh = 5'b10000;
            default: oh = 5'b00000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/r_block_xy_dec.sv
// Combinational XY routing decoder: X resolved first, then Y, else Local.
// Coordinates are only compared for equality; direction comes from the
// delta-sign bits supplied with the flit.
module r_block_xy_dec
    import global_params::*;
#(
    parameter int X_COORD = 0,
    parameter int Y_COORD = 0,
    parameter int COORD_W = 2
) (
    input  logic [COORD_W-1:0] dest_x,
    input  logic [COORD_W-1:0] dest_y,
    input  logic               s_delta_x,
    input  logic               s_delta_y,
    input  logic               valid,
    output logic [DIR_N-1:0]   route_oh
);

    localparam logic [COORD_W-1:0] X_C = X_COORD[COORD_W-1:0];
    localparam logic [COORD_W-1:0] Y_C = Y_COORD[COORD_W-1:0];

    dir_e dir_s;

    // Select the output direction and expand it to a one-hot request
    always_comb begin
        dir_s    = LOCAL;
        route_oh = {DIR_N{1'b0}};
        if (dest_x != X_C) begin
            if (s_delta_x) begin
                dir_s = WEST;
            end else begin
                dir_s = EAST;
            end
        end else if (dest_y != Y_C) begin
            if (s_delta_y) begin
                dir_s = NORTH;
            end else begin
                dir_s = SOUTH;
            end
        end else begin
            dir_s = LOCAL;
        end
        if (valid) begin
            route_oh = dir_onehot(dir_s);
        end else begin
            route_oh = {DIR_N{1'b0}};
        end
    end

endmodule

// File: rtl/r_block_xy.sv
// XY routing decision block for one mesh router: registers the one-hot port
// request produced by r_block_xy_dec (one cycle latency, one flit per cycle).
// Optional build macro R_BLOCK_SIGN_CHECK_EN adds a registered sign_err flag
// that reports delta-sign bits inconsistent with the destination coordinates.
module r_block_xy
    import global_params::*;
#(
    parameter int X_COORD   = 0,
    parameter int Y_COORD   = 0,
    parameter int MESH_SIDE = global_params::MESH_SIDE,
    localparam int COORD_W  = (MESH_SIDE > 2) ? $clog2(MESH_SIDE) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] dest_x,
    input  logic [COORD_W-1:0] dest_y,
    input  logic               s_delta_x,
    input  logic               s_delta_y,
    input  logic               valid,
    output logic               route_north,
    output logic               route_east,
    output logic               route_south,
    output logic               route_west,
`ifdef R_BLOCK_SIGN_CHECK_EN
    output logic               sign_err,
`endif
    output logic               route_local
);

    logic [DIR_N-1:0] route_oh_s;
    logic [DIR_N-1:0] route_r;

    r_block_xy_dec #(
        .X_COORD (X_COORD),
        .Y_COORD (Y_COORD),
        .COORD_W (COORD_W)
    ) u_dec (
        .dest_x    (dest_x),
        .dest_y    (dest_y),
        .s_delta_x (s_delta_x),
        .s_delta_y (s_delta_y),
        .valid     (valid),
        .route_oh  (route_oh_s)
    );

    // Route request register with synchronous reset overriding valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            route_r <= {DIR_N{1'b0}};
        end else begin
            route_r <= route_oh_s;
        end
    end

    assign route_north = route_r[NORTH];
    assign route_east  = route_r[EAST];
    assign route_south = route_r[SOUTH];
    assign route_west  = route_r[WEST];
    assign route_local = route_r[LOCAL];

`ifdef R_BLOCK_SIGN_CHECK_EN
    localparam logic [COORD_W-1:0] X_C = X_COORD[COORD_W-1:0];
    localparam logic [COORD_W-1:0] Y_C = Y_COORD[COORD_W-1:0];

    logic sign_err_s;
    logic sign_err_r;

    // Flag a sign bit that contradicts the magnitude of the resolved axis
    always_comb begin
        sign_err_s = 1'b0;
        if (!valid) begin
            sign_err_s = 1'b0;
        end else if (dest_x != X_C) begin
            sign_err_s = (s_delta_x != (dest_x < X_C));
        end else if (dest_y != Y_C) begin
            sign_err_s = (s_delta_y != (dest_y < Y_C));
        end else begin
            sign_err_s = 1'b0;
        end
    end

    // Sign error flag register, aligned with the route request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_err_r <= 1'b0;
        end else begin
            sign_err_r <= sign_err_s;
        end
    end

    assign sign_err = sign_err_r;
`endif

endmodule

// File: tb/tb_r_block_xy.sv
// Directed self-checking bench for r_block_xy at X_COORD=1, Y_COORD=1,
// MESH_SIDE=3. Outputs are sampled 1 ns after the rising edge.
module tb_r_block_xy;

    logic       clk;
    logic       rst_n;
    logic [1:0] dest_x;
    logic [1:0] dest_y;
    logic       s_delta_x;
    logic       s_delta_y;
    logic       valid;
    logic       route_north;
    logic       route_east;
    logic       route_south;
    logic       route_west;
    logic       route_local;
    logic       sign_err_obs;
`ifdef R_BLOCK_SIGN_CHECK_EN
    logic       sign_err;
    assign sign_err_obs = sign_err;
`else
    assign sign_err_obs = 1'b0;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    r_block_xy #(
        .X_COORD   (1),
        .Y_COORD   (1),
        .MESH_SIDE (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dest_x      (dest_x),
        .dest_y      (dest_y),
        .s_delta_x   (s_delta_x),
        .s_delta_y   (s_delta_y),
        .valid       (valid),
        .route_north (route_north),
        .route_east  (route_east),
        .route_south (route_south),
        .route_west  (route_west),
`ifdef R_BLOCK_SIGN_CHECK_EN
        .sign_err    (sign_err),
`endif
        .route_local (route_local)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [4:0] R_0 = 5'b00000;
    localparam logic [4:0] R_N = 5'b00001;
    localparam logic [4:0] R_E = 5'b00010;
    localparam logic [4:0] R_S = 5'b00100;
    localparam logic [4:0] R_W = 5'b01000;
    localparam logic [4:0] R_L = 5'b10000;

    task automatic check(input string tag, input logic [4:0] exp_route, input logic exp_err);
        logic [4:0] obs;
        obs = {route_local, route_west, route_south, route_east, route_north};
        n_assert++;
        assert (obs === exp_route) else begin
            n_fail++;
            $error("FAIL %s: route observed %b expected %b", tag, obs, exp_route);
        end
`ifdef R_BLOCK_SIGN_CHECK_EN
        n_assert++;
        assert (sign_err_obs === exp_err) else begin
            n_fail++;
            $error("FAIL %s_err: sign_err observed %b expected %b", tag, sign_err_obs, exp_err);
        end
`endif
    endtask

    // Drive one vector, take one rising edge, check the registered result
    task automatic step(input string tag, input logic rst, input logic v,
                        input logic [1:0] dx, input logic [1:0] dy,
                        input logic sdx, input logic sdy,
                        input logic [4:0] exp_route, input logic exp_err);
        rst_n     = rst;
        valid     = v;
        dest_x    = dx;
        dest_y    = dy;
        s_delta_x = sdx;
        s_delta_y = sdy;
        @(posedge clk);
        #1;
        check(tag, exp_route, exp_err);
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b1; dest_x = 2'd0; dest_y = 2'd0;
        s_delta_x = 1'b1; s_delta_y = 1'b1;
        #2;

        // Reset overrides valid
        step("rst0", 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1, R_0, 1'b0);
        step("rst1", 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1, R_0, 1'b0);
        step("rel_e", 1'b1, 1'b1, 2'd2, 2'd2, 1'b0, 1'b0, R_E, 1'b0);

        // X first
        step("x_w",  1'b1, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1, R_W, 1'b0);
        step("x_l",  1'b1, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, R_L, 1'b0);
        step("x_e",  1'b1, 1'b1, 2'd2, 2'd2, 1'b0, 1'b0, R_E, 1'b0);
        step("x_w2", 1'b1, 1'b1, 2'd0, 2'd2, 1'b1, 1'b0, R_W, 1'b0);

        // Y routing once X matches
        step("y_n", 1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 1'b1, R_N, 1'b0);
        step("y_l", 1'b1, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, R_L, 1'b0);
        step("y_s", 1'b1, 1'b1, 2'd1, 2'd2, 1'b0, 1'b0, R_S, 1'b0);
        step("l_sign_ign", 1'b1, 1'b1, 2'd1, 2'd1, 1'b1, 1'b1, R_L, 1'b0);

        // valid=0 suppresses everything
        step("nv_w", 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, R_0, 1'b0);
        step("nv_l", 1'b1, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0, R_0, 1'b0);
        step("nv_e", 1'b1, 1'b0, 2'd2, 2'd2, 1'b0, 1'b0, R_0, 1'b0);

        // Sign bits decide direction; illegal coordinates use equality only
        step("sgn_e",  1'b1, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, R_E, 1'b1);
        step("ill_x",  1'b1, 1'b1, 2'd3, 2'd1, 1'b0, 1'b0, R_E, 1'b0);
        step("ill_y",  1'b1, 1'b1, 2'd1, 2'd3, 1'b0, 1'b1, R_N, 1'b1);
        step("sgn_s",  1'b1, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0, R_S, 1'b1);

        // Inputs changing between edges are not visible
        step("hold0", 1'b1, 1'b1, 2'd2, 2'd0, 1'b0, 1'b1, R_E, 1'b0);
        dest_x = 2'd0; s_delta_x = 1'b1; dest_y = 2'd1;
        #3;
        check("hold_mid", R_E, 1'b0);
        @(posedge clk);
        #1;
        check("hold1", R_W, 1'b0);

        // Mid-stream reset for one edge, then routing resumes
        step("mr_pre", 1'b1, 1'b1, 2'd1, 2'd2, 1'b0, 1'b0, R_S, 1'b0);
        step("mr_rst", 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 1'b1, R_0, 1'b0);
        step("mr_res", 1'b1, 1'b1, 2'd2, 2'd2, 1'b0, 1'b0, R_E, 1'b0);

        // Sign consistency flag cases
        step("se_w", 1'b1, 1'b1, 2'd2, 2'd1, 1'b1, 1'b0, R_W, 1'b1);
        step("se_e", 1'b1, 1'b1, 2'd2, 2'd1, 1'b0, 1'b0, R_E, 1'b0);
        step("se_nv", 1'b1, 1'b0, 2'd2, 2'd1, 1'b1, 1'b0, R_0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/r_block_xy.md
Name: r_block_xy

Overview:
- Per-router XY (dimension-ordered) routing decision block for the 2-D mesh NoC without diagonals.
- Takes a flit's destination coordinates and delta-sign bits, and produces a one-hot output-port request: North, East, South, West or Local.
- Resolves X first, then Y.
- The request is registered: one cycle of latency into the router's switch allocator.

Parameters:
- X_COORD, 0, column of this router (0..MESH_SIDE-1).
- Y_COORD, 0, row of this router (0..MESH_SIDE-1).
- MESH_SIDE, global_params::MESH_SIDE (3), routers per mesh side; coordinate width COORD_W = max(1, $clog2(MESH_SIDE)).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- dest_x  in  COORD_W  destination column.
- dest_y  in  COORD_W  destination row.
- s_delta_x  in  1  sign of the X delta; 1 = destination column < X_COORD (go West), 0 = go East.
- s_delta_y  in  1  sign of the Y delta; 1 = destination row < Y_COORD (go North), 0 = go South.
- valid  in  1  a flit header is present on the inputs.
- route_north  out  1  request the North port.
- route_east  out  1  request the East port.
- route_south  out  1  request the South port.
- route_west  out  1  request the West port.
- route_local  out  1  request ejection to the local PE.

Behaviour:
- Reset: when rst_n=0 at a rising clk edge, all five route_* outputs go to 0 (and sign_err, if present). Reset overrides valid.
- Decode (combinational), then registered on each rising edge when rst_n=1. Outputs reflect the inputs sampled on the previous edge (latency 1 cycle, throughput 1 per cycle, no stall/ready).
- valid=0 → all outputs 0 on the next cycle, regardless of the other inputs.
- valid=1 and dest_x != X_COORD → s_delta_x=1: West; s_delta_x=0: East.
- valid=1, dest_x == X_COORD, dest_y != Y_COORD → s_delta_y=1: North; s_delta_y=0: South.
- valid=1, dest_x == X_COORD, dest_y == Y_COORD → Local. Sign bits are ignored.
- Coordinates are compared for equality only. Direction comes solely from the sign bits; the block never infers direction from magnitude.
- Output is exactly one-hot when valid was 1, all-zero otherwise. Two asserted outputs is a bug.
- Destination values ≥ MESH_SIDE are not legal. They are still decoded by the same equality rules; no saturation or wrap.
- Edge routers: no blocking of nonexistent ports (e.g. West at X_COORD=0). A correct upstream never requests one.
- Input changes between edges are invisible; only edge-sampled values matter.

Optional Feature:
- Macro: R_BLOCK_SIGN_CHECK_EN.
- Defined:
  - Adds output sign_err (1 bit, registered, reset 0).
  - sign_err is asserted the cycle after valid=1 when s_delta_x disagrees with (dest_x < X_COORD) while dest_x != X_COORD.
  - It is also asserted when s_delta_y disagrees with (dest_y < Y_COORD) while dest_x == X_COORD and dest_y != Y_COORD.
  - Routing outputs are unchanged; the sign bits still win.
- Undefined: no sign_err port, no comparators; behaviour is otherwise identical.

Decomposition:
- global_params package: MESH_SIDE.
- Same package: dir_e enum (NORTH=0, EAST=1, SOUTH=2, WEST=3, LOCAL=4) and DIR_N=5, so bit order matches out[4:0] = {local, west, south, east, north}.
- Natural sub-module: r_block_xy_dec, a purely combinational decoder producing a 5-bit one-hot from the inputs. The top level holds the register, reset and optional check.

Test Plan (X_COORD=1, Y_COORD=1, MESH_SIDE=3; outputs checked one cycle after sampling):
- Reset: rst_n=0 for 2 cycles with valid=1, dx=0 → all outputs 0. Release, dx=2,dy=2,sdx=0,sdy=0,valid=1 → next cycle E=1 only.
- X first: (dx,dy,sdx,sdy) = (0,0,1,1) → W=1; (1,1,0,0) → Local=1; (2,2,0,0) → E=1; each exactly one-hot.
- Y routing, dx=1,sdx=0: (dy=0,sdy=1) → N=1; (dy=1,sdy=0) → Local=1; (dy=2,sdy=0) → S=1.
- valid=0 across the X-first vectors (0,0,1,1), (1,1,0,0), (2,2,0,0) → all outputs 0 each cycle.
- Latency/mid-reset: back-to-back vectors change outputs every cycle with 1-cycle lag. rst_n=0 for one edge mid-stream → outputs 0 on that cycle; routing resumes the next cycle.
- With R_BLOCK_SIGN_CHECK_EN: dx=2,sdx=1,valid=1 → W=1 and sign_err=1. dx=2,sdx=0 → E=1, sign_err=0.
